// File: rtl/epp_host_pkg.sv
// -----------------------------------------------------------------------------
// epp_host_pkg
//   Shared definitions for the host-side EPP engine:
//   - command op encodings (address/data x write/read),
//   - FSM state encodings (plain localparams for legacy-compatible tools),
//   - default timing constants,
//   - small decode helpers for the op field.
//   Optional feature macro used by the engine: EPP_HOST_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package epp_host_pkg;

  // Command op field: [1] = 0 address cycle / 1 data cycle,
  //                   [0] = 0 write / 1 read
  localparam logic [1:0] OP_ADR_WR = 2'b00;
  localparam logic [1:0] OP_ADR_RD = 2'b01;
  localparam logic [1:0] OP_DAT_WR = 2'b10;
  localparam logic [1:0] OP_DAT_RD = 2'b11;

  // FSM states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETUP   = 2'd1;
  localparam logic [1:0] ST_STROBE  = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  // Default timing
  localparam int DEF_SETUP_CYC   = 2;
  localparam int DEF_TIMEOUT_CYC = 1000;
  localparam int DEF_CNT_W       = 10;

  // Decoded view of a latched command
  typedef struct packed {
    logic isData;   // 1 = data strobe, 0 = address strobe
    logic isRead;   // 1 = read cycle, 0 = write cycle
  } cmd_attr_t;

  function automatic cmd_attr_t decodeOp(input logic [1:0] op);
    cmd_attr_t a;
    a.isData = (op == OP_DAT_WR) || (op == OP_DAT_RD);
    a.isRead = (op == OP_ADR_RD) || (op == OP_DAT_RD);
    return a;
  endfunction

endpackage

// File: rtl/epp_host_if.sv
// -----------------------------------------------------------------------------
// epp_host_if
//   Bundles the local command/response handshake and the EPP bus pins of the
//   host engine.
//   modport master : the host engine (drives cmd_ready, rsp_*, strobes, bus out)
//   modport slave  : local logic + peripheral side (drives cmd_*, eppDbIn,
//                    eppWait)
//   Signals:
//     cmd_valid/cmd_ready/cmd_op[1:0]/cmd_data[7:0]  command handshake
//     rsp_valid/rsp_data[7:0]/rsp_timeout            completion pulse
//     eppDbOut[7:0]/eppDbIn[7:0]/eppDbOe             split bidirectional data
//     eppAstb/eppDstb (active-low), eppWrite, eppWait
// -----------------------------------------------------------------------------
interface epp_host_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;

  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_timeout;

  logic [7:0] eppDbOut;
  logic [7:0] eppDbIn;
  logic       eppDbOe;
  logic       eppAstb;
  logic       eppDstb;
  logic       eppWrite;
  logic       eppWait;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, eppDbIn, eppWait,
    output cmd_ready, rsp_valid, rsp_data, rsp_timeout,
           eppDbOut, eppDbOe, eppAstb, eppDstb, eppWrite
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, eppDbIn, eppWait,
    input  cmd_ready, rsp_valid, rsp_data, rsp_timeout,
           eppDbOut, eppDbOe, eppAstb, eppDstb, eppWrite
  );

endinterface

// File: rtl/epp_sync2.sv
// -----------------------------------------------------------------------------
// epp_sync2
//   Two-flop synchronizer for a single asynchronous level (eppWait).
//   Both flops clear to 0 on reset, so the engine sees "peripheral not ready"
//   until the pin has been observed for two clocks.
//   Ports: clk, rst (async, active-high), d (async in), q (synchronized out)
// -----------------------------------------------------------------------------
module epp_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_p0 <= 1'b0;
      q       <= 1'b0;
    end else begin
      // stage 0: metastability catch
      meta_p0 <= d;
      // stage 1: synchronized output
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/epp_host_master.sv
// -----------------------------------------------------------------------------
// epp_host_master
//   Host-side EPP initiator. Accepts one command at a time from local logic,
//   runs a fully interlocked address or data strobe cycle with the peripheral
//   (strobe low -> wait high -> strobe high -> wait low) and returns a
//   one-cycle response carrying read data or a timeout flag.
//
//   Parameters:
//     SETUP_CYC    clocks of data/eppWrite setup before the strobe falls
//                  (0 behaves as 1)
//     TIMEOUT_CYC  max clocks spent in either wait phase (timeout build only)
//     CNT_W        width of the shared setup/timeout counter
//
//   Ports:
//     clk   system clock
//     rst   asynchronous reset, active-high; releases strobes and bus at once
//     bus   epp_host_if.master: cmd_*/rsp_* handshake and EPP pins
//
//   Configuration macro:
//     EPP_HOST_TIMEOUT_EN  defined  -> both wait phases abort after
//                                      TIMEOUT_CYC clocks with rsp_timeout=1
//                          undefined -> wait phases wait indefinitely,
//                                       rsp_timeout stays 0
// -----------------------------------------------------------------------------
module epp_host_master
  import epp_host_pkg::*;
#(
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  epp_host_if.master bus
);

  localparam int              SETUP_EFF  = (SETUP_CYC < 1) ? 1 : SETUP_CYC;
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_EFF - 1);

  // Both counter loads must fit the shared counter.
  if ((TIMEOUT_CYC < 1) || (TIMEOUT_CYC - 1 >= (1 << CNT_W)) ||
      (SETUP_EFF - 1 >= (1 << CNT_W))) begin : gBadCfg
    $error("epp_host_master: CNT_W too small for SETUP_CYC/TIMEOUT_CYC");
  end

`ifdef EPP_HOST_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
`endif

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  cmd_attr_t        attr;
  cmd_attr_t        newAttr;
  logic             waitS;

  assign newAttr = decodeOp(bus.cmd_op);

  // eppWait is asynchronous to clk; every decision uses the synchronized copy.
  epp_sync2 u_waitSync (
    .clk (clk),
    .rst (rst),
    .d   (bus.eppWait),
    .q   (waitS)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      attr            <= '0;
      bus.cmd_ready   <= 1'b1;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_data    <= '0;
      bus.rsp_timeout <= 1'b0;
      bus.eppDbOut    <= '0;
      bus.eppDbOe     <= 1'b0;
      bus.eppAstb     <= 1'b1;
      bus.eppDstb     <= 1'b1;
      bus.eppWrite    <= 1'b1;
    end else begin
      bus.rsp_valid <= 1'b0;

      case (state)
        // IDLE: latch the command and present direction/data for setup
        ST_IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            attr          <= newAttr;
            bus.cmd_ready <= 1'b0;
            bus.eppWrite  <= newAttr.isRead;
            bus.eppDbOe   <= !newAttr.isRead;
            if (!newAttr.isRead) begin
              bus.eppDbOut <= bus.cmd_data;
            end
            cnt   <= SETUP_LOAD;
            state <= ST_SETUP;
          end
        end

        // SETUP: bus has been stable for SETUP_EFF clocks when cnt hits 0
        ST_SETUP: begin
          if (cnt == '0) begin
            if (attr.isData) begin
              bus.eppDstb <= 1'b0;
            end else begin
              bus.eppAstb <= 1'b0;
            end
            cnt   <= '0;
            state <= ST_STROBE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        // STROBE: hold strobe until the peripheral signals ready
        ST_STROBE: begin
          if (waitS) begin
            if (attr.isRead) begin
              bus.rsp_data <= bus.eppDbIn;
            end
            bus.eppAstb <= 1'b1;
            bus.eppDstb <= 1'b1;
            cnt         <= '0;
            state       <= ST_RELEASE;
          end
`ifdef EPP_HOST_TIMEOUT_EN
          else if (cnt == TIMEOUT_LAST) begin
            bus.eppAstb     <= 1'b1;
            bus.eppDstb     <= 1'b1;
            bus.eppDbOe     <= 1'b0;
            bus.eppWrite    <= 1'b1;
            bus.rsp_valid   <= 1'b1;
            bus.rsp_timeout <= 1'b1;
            bus.rsp_data    <= '0;
            bus.cmd_ready   <= 1'b1;
            state           <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end

        // RELEASE: cycle is only finished once the peripheral drops wait,
        // even if wait was already high when the strobe fell.
        ST_RELEASE: begin
          if (!waitS) begin
            bus.eppWrite    <= 1'b1;
            bus.eppDbOe     <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            bus.rsp_timeout <= 1'b0;
            if (!attr.isRead) begin
              bus.rsp_data <= '0;
            end
            bus.cmd_ready   <= 1'b1;
            state           <= ST_IDLE;
          end
`ifdef EPP_HOST_TIMEOUT_EN
          else if (cnt == TIMEOUT_LAST) begin
            bus.eppAstb     <= 1'b1;
            bus.eppDstb     <= 1'b1;
            bus.eppDbOe     <= 1'b0;
            bus.eppWrite    <= 1'b1;
            bus.rsp_valid   <= 1'b1;
            bus.rsp_timeout <= 1'b1;
            bus.rsp_data    <= '0;
            bus.cmd_ready   <= 1'b1;
            state           <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_epp_host_master.sv
// -----------------------------------------------------------------------------
// tb_epp_host_master
//   Directed bench for epp_host_master with a behavioural EPP peripheral and a
//   response scoreboard. Expected responses are queued when a command is
//   accepted and compared when rsp_valid pulses.
// -----------------------------------------------------------------------------
module tb_epp_host_master;
  import epp_host_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  epp_host_if bus();

  epp_host_master #(
    .SETUP_CYC   (2),
    .TIMEOUT_CYC (16),
    .CNT_W       (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] data;
    logic       to;
  } rsp_t;
  rsp_t expQ[$];

  // Peripheral model control: 0 = respond respDelay clk after strobe low,
  // 1 = wait stuck low, 2 = wait held high until a strobe has come and gone.
  int         pmode     = 0;
  int         respDelay = 2;
  logic [7:0] readByte  = 8'h00;
  int         lowCnt    = 0;
  bit         seenLow   = 0;
  int         dstbPulses = 0;
  logic       prevDstb  = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural peripheral
  always @(posedge clk) begin
    logic strobeLow;
    strobeLow = (bus.eppAstb === 1'b0) || (bus.eppDstb === 1'b0);
    if (rst) begin
      bus.eppWait <= 1'b0;
      bus.eppDbIn <= 8'h00;
      lowCnt  = 0;
      seenLow = 0;
    end else begin
      case (pmode)
        0: begin
          seenLow = 0;
          if (strobeLow) begin
            if (lowCnt == respDelay - 1) begin
              bus.eppDbIn <= readByte;
              bus.eppWait <= 1'b1;
            end
            lowCnt++;
          end else begin
            lowCnt = 0;
            bus.eppWait <= 1'b0;
          end
        end
        1: begin
          lowCnt  = 0;
          seenLow = 0;
          bus.eppWait <= 1'b0;
        end
        default: begin
          bus.eppDbIn <= readByte;
          if (strobeLow) begin
            seenLow = 1;
            bus.eppWait <= 1'b1;
          end else if (seenLow) begin
            bus.eppWait <= 1'b0;
          end else begin
            bus.eppWait <= 1'b1;
          end
        end
      endcase
    end
  end

  // Response scoreboard and bus-protocol monitor
  always @(negedge clk) begin
    rsp_t e;
    if (rst !== 1'b1) begin
      checks++;
      assert (!(bus.eppAstb === 1'b0 && bus.eppDstb === 1'b0)) else begin
        failures++;
        $error("FAIL both_strobes observed=%b%b expected=not 00", bus.eppAstb, bus.eppDstb);
      end
      if (bus.rsp_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL unexpected_rsp observed=rsp_valid=1 expected=no response");
        end else begin
          e = expQ.pop_front();
          checks++;
          assert (bus.rsp_data === e.data) else begin
            failures++;
            $error("FAIL rsp_data observed=0x%0h expected=0x%0h", bus.rsp_data, e.data);
          end
          checks++;
          assert (bus.rsp_timeout === e.to) else begin
            failures++;
            $error("FAIL rsp_timeout observed=%b expected=%b", bus.rsp_timeout, e.to);
          end
        end
      end
      if (prevDstb === 1'b1 && bus.eppDstb === 1'b0) dstbPulses++;
      prevDstb = bus.eppDstb;
    end
  end

  // Present a command and hold cmd_valid until it is accepted. Returns at the
  // falling edge just after the accepting clock edge; cmd_valid stays high.
  task automatic send(input logic [1:0] op, input logic [7:0] d,
                      input logic [7:0] expData, input logic expTo,
                      input bit expectRsp);
    bit ok;
    ok = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    for (int i = 0; i < 400; i++) begin
      if (bus.cmd_ready === 1'b1) begin
        if (expectRsp) expQ.push_back('{data: expData, to: expTo});
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      failures++;
      $error("FAIL accept_wait observed=never ready expected=cmd accepted");
    end
    @(negedge clk);
  endtask

  // Wait (bounded) for every queued response to arrive.
  task automatic waitIdle(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (expQ.size() == 0) break;
      @(negedge clk);
    end
    if (expQ.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL rsp_wait observed=%0d pending expected=0 pending", expQ.size());
      expQ.delete();
    end
    @(negedge clk);
  endtask

  task automatic waitDstbLow(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (bus.eppDstb === 1'b0) break;
      @(negedge clk);
    end
    chk("dstb_fall", 32'(bus.eppDstb), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=still running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    int  base;
    bit  badOe, badAstb, badWr, sawDstb;

    // ---------------- reset state ----------------
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready",   32'(bus.cmd_ready),   32'd1);
    chk("rst_rsp_valid",   32'(bus.rsp_valid),   32'd0);
    chk("rst_rsp_data",    32'(bus.rsp_data),    32'd0);
    chk("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    chk("rst_eppDbOut",    32'(bus.eppDbOut),    32'd0);
    chk("rst_eppDbOe",     32'(bus.eppDbOe),     32'd0);
    chk("rst_eppAstb",     32'(bus.eppAstb),     32'd1);
    chk("rst_eppDstb",     32'(bus.eppDstb),     32'd1);
    chk("rst_eppWrite",    32'(bus.eppWrite),    32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ---------------- 1: address write 0x01 ----------------
    pmode = 0; respDelay = 2;
    send(OP_ADR_WR, 8'h01, 8'h00, 1'b0, 1'b1);
    bus.cmd_valid = 1'b0;
    chk("t1_setup0_write", 32'(bus.eppWrite), 32'd0);
    chk("t1_setup0_dbout", 32'(bus.eppDbOut), 32'h01);
    chk("t1_setup0_oe",    32'(bus.eppDbOe),  32'd1);
    chk("t1_setup0_astb",  32'(bus.eppAstb),  32'd1);
    chk("t1_busy_ready",   32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    chk("t1_setup1_astb",  32'(bus.eppAstb),  32'd1);
    chk("t1_setup1_dbout", 32'(bus.eppDbOut), 32'h01);
    @(negedge clk);
    chk("t1_astb_low",     32'(bus.eppAstb),  32'd0);
    chk("t1_dstb_high",    32'(bus.eppDstb),  32'd1);
    chk("t1_strobe_write", 32'(bus.eppWrite), 32'd0);
    waitIdle(100);
    chk("t1_done_write",   32'(bus.eppWrite),  32'd1);
    chk("t1_done_oe",      32'(bus.eppDbOe),   32'd0);
    chk("t1_done_ready",   32'(bus.cmd_ready), 32'd1);

    // ---------------- 2: data read 0xA5 ----------------
    readByte = 8'hA5;
    send(OP_DAT_RD, 8'h77, 8'hA5, 1'b0, 1'b1);
    bus.cmd_valid = 1'b0;
    badOe = 0; badAstb = 0; badWr = 0; sawDstb = 0;
    for (int i = 0; i < 100; i++) begin
      if (expQ.size() == 0) break;
      if (bus.eppDbOe !== 1'b0) badOe = 1;
      if (bus.eppAstb !== 1'b1) badAstb = 1;
      if (bus.eppWrite !== 1'b1) badWr = 1;
      if (bus.eppDstb === 1'b0) sawDstb = 1;
      @(negedge clk);
    end
    chk("t2_oe_never", 32'(badOe),   32'd0);
    chk("t2_astb_idle", 32'(badAstb), 32'd0);
    chk("t2_write_hi", 32'(badWr),   32'd0);
    chk("t2_dstb_seen", 32'(sawDstb), 32'd1);
    waitIdle(100);
    repeat (3) @(negedge clk);
    chk("t2_rsp_hold", 32'(bus.rsp_data), 32'hA5);

`ifdef EPP_HOST_TIMEOUT_EN
    // ---------------- 3: data write 0x3C, wait stuck low ----------------
    pmode = 1;
    send(OP_DAT_WR, 8'h3C, 8'h00, 1'b1, 1'b1);
    bus.cmd_valid = 1'b0;
    waitDstbLow(20);
    n = 0;
    while (bus.eppDstb === 1'b0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("t3_strobe_cycles", 32'(n), 32'd16);
    chk("t3_oe_released",   32'(bus.eppDbOe),  32'd0);
    chk("t3_write_hi",      32'(bus.eppWrite), 32'd1);
    waitIdle(20);
    chk("t3_ready",         32'(bus.cmd_ready), 32'd1);
    chk("t3_rsp_data_clr",  32'(bus.rsp_data),  32'd0);
    pmode = 0;
`endif

    // ---------------- 4: back-to-back data writes ----------------
    pmode = 0; respDelay = 1;
    base = dstbPulses;
    for (int k = 0; k < 4; k++) begin
      send(OP_DAT_WR, 8'h10 + 8'(k), 8'h00, 1'b0, 1'b1);
      chk("t4_dbout", 32'(bus.eppDbOut), 32'h10 + 32'(k));
      chk("t4_busy",  32'(bus.cmd_ready), 32'd0);
    end
    bus.cmd_valid = 1'b0;
    waitIdle(200);
    chk("t4_pulses", 32'(dstbPulses - base), 32'd4);

    // ---------------- 5: reset while eppDstb low ----------------
    pmode = 1;
    send(OP_DAT_WR, 8'h55, 8'h00, 1'b0, 1'b0);
    bus.cmd_valid = 1'b0;
    waitDstbLow(20);
    chk("t5_oe_before", 32'(bus.eppDbOe), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_dstb",  32'(bus.eppDstb),   32'd1);
    chk("t5_rst_oe",    32'(bus.eppDbOe),   32'd0);
    chk("t5_rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t5_rst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("t5_rst_write", 32'(bus.eppWrite),  32'd1);
    expQ.delete();
    @(negedge clk);
    rst = 1'b0;
    pmode = 0; respDelay = 2;
    send(OP_DAT_WR, 8'h5A, 8'h00, 1'b0, 1'b1);
    bus.cmd_valid = 1'b0;
    chk("t5_after_dbout", 32'(bus.eppDbOut), 32'h5A);
    waitIdle(100);
    chk("t5_after_ready", 32'(bus.cmd_ready), 32'd1);

    // ---------------- 6: wait already high before command ----------------
    pmode = 2; readByte = 8'hC3;
    repeat (4) @(negedge clk);
    send(OP_ADR_RD, 8'h00, 8'hC3, 1'b0, 1'b1);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.eppAstb === 1'b0) break;
      @(negedge clk);
    end
    chk("t6_astb_low", 32'(bus.eppAstb), 32'd0);
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_release_latency", 32'(n), 32'd5);
    waitIdle(50);
    chk("t6_ready", 32'(bus.cmd_ready), 32'd1);
    chk("t6_rsp_hold", 32'(bus.rsp_data), 32'hC3);

`ifndef EPP_HOST_TIMEOUT_EN
    // Without timeout support a stuck peripheral stalls the engine forever.
    pmode = 1;
    send(OP_ADR_WR, 8'h42, 8'h00, 1'b0, 1'b0);
    bus.cmd_valid = 1'b0;
    repeat (60) @(negedge clk);
    chk("t6_stuck_astb",  32'(bus.eppAstb),   32'd0);
    chk("t6_stuck_ready", 32'(bus.cmd_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pmode = 0;
    @(negedge clk);
    chk("t6_recover_ready", 32'(bus.cmd_ready), 32'd1);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
